// File: rtl/cpu_pkg.sv
// Types and constants shared by the CPU, its program RAM and the RAM program loader.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StCsum,
    StDone,
    StError
  } loader_state_e;

endpackage

// File: rtl/ram_program_loader.sv
// Receives a framed big-endian byte stream and writes 16-bit words into program RAM,
// holding the CPU in reset until the image is complete. Build option: LOADER_CSUM_EN.
module ram_program_loader
  import cpu_pkg::*;
#(
  parameter int unsigned      ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned      MAX_WORDS = 256,
  parameter logic [7:0]       SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [WORD_W-1:0] ram_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

`ifdef LOADER_CSUM_EN
  localparam loader_state_e EndState = StCsum;
`else
  localparam loader_state_e EndState = StDone;
`endif

  loader_state_e     state_q, state_d;
  logic              in_ready_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_waddr_q;
  logic [WORD_W-1:0] ram_wdata_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              error_q;
  logic [15:0]       words_loaded_q;
  logic [15:0]       length_q;
  logic [7:0]        hi_q;
`ifdef LOADER_CSUM_EN
  logic [7:0]        sum_q;
`endif

  logic        xfer;
  logic [15:0] len_in;
  logic        len_oversize;
  logic        last_word;
  logic        rearm;

  assign xfer         = in_valid && in_ready_q;
  assign len_in       = {length_q[15:8], in_byte};
  assign len_oversize = 32'(len_in) > MAX_WORDS;
  assign last_word    = (words_loaded_q + 16'd1) == length_q;
  assign rearm        = restart && (state_q == StDone || state_q == StError);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (xfer && in_byte == SYNC_BYTE) state_d = StLenHi;
      StLenHi:  if (xfer) state_d = StLenLo;
      StLenLo: begin
        if (xfer) begin
          if (len_in == 16'd0)   state_d = EndState;
          else if (len_oversize) state_d = StError;
          else                   state_d = StDataHi;
        end
      end
      StDataHi: if (xfer) state_d = StDataLo;
      StDataLo: if (xfer) state_d = last_word ? EndState : StDataHi;
`ifdef LOADER_CSUM_EN
      StCsum:   if (xfer) state_d = (in_byte == sum_q) ? StDone : StError;
`endif
      StDone, StError: if (rearm) state_d = StIdle;
      default:  state_d = StError;
    endcase
  end

  // Status outputs are registered from the next state so they change on the entry edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      in_ready_q     <= 1'b1;
      ram_we_q       <= 1'b0;
      ram_waddr_q    <= BASE_ADDR;
      ram_wdata_q    <= '0;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
      length_q       <= '0;
      hi_q           <= '0;
`ifdef LOADER_CSUM_EN
      sum_q          <= '0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StDone) && (state_d != StError);
      cpu_hold_q <= (state_d != StDone);
      done_q     <= (state_d == StDone);
      error_q    <= (state_d == StError);
      ram_we_q   <= 1'b0;

      if (xfer) begin
        case (state_q)
          StIdle: begin
            if (in_byte == SYNC_BYTE) begin
              words_loaded_q <= '0;
`ifdef LOADER_CSUM_EN
              sum_q          <= '0;
`endif
            end
          end
          StLenHi: length_q[15:8] <= in_byte;
          StLenLo: length_q[7:0]  <= in_byte;
          StDataHi: begin
            hi_q <= in_byte;
`ifdef LOADER_CSUM_EN
            sum_q <= sum_q + in_byte;
`endif
          end
          StDataLo: begin
            ram_we_q       <= 1'b1;
            ram_wdata_q    <= {hi_q, in_byte};
            ram_waddr_q    <= BASE_ADDR + ADDR_W'(words_loaded_q);
            words_loaded_q <= words_loaded_q + 16'd1;
`ifdef LOADER_CSUM_EN
            sum_q          <= sum_q + in_byte;
`endif
          end
          default: ;
        endcase
      end

      if (rearm) words_loaded_q <= '0;
    end
  end

  assign in_ready     = in_ready_q;
  assign ram_we       = ram_we_q;
  assign ram_waddr    = ram_waddr_q;
  assign ram_wdata    = ram_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: doc/ram_program_loader.md
Name: ram_program_loader

Overview:
- Write-side counterpart of the CPU's instruction fetch path: receives a framed byte stream and writes 16-bit instruction words into program RAM.
- Holds the CPU in reset (cpu_hold) until a complete, valid image has been written, then releases it.
- Sits between the host byte source (serial receiver or testbench) and the RAM write port. The CPU keeps the RAM read port.

Parameters:
- ADDR_W, 16, RAM address width.
- BASE_ADDR, 16'h0000, RAM address of the first loaded word.
- MAX_WORDS, 256, largest accepted image length in words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_byte  in  8  incoming stream byte
- in_valid  in  1  in_byte valid
- in_ready  out  1  loader accepts byte; a transfer occurs when in_valid && in_ready on a clk rising edge
- restart  in  1  re-arm pulse; acted on only in DONE or ERROR
- ram_we  out  1  one-cycle RAM write strobe
- ram_waddr  out  ADDR_W  write address
- ram_wdata  out  16  write data
- cpu_hold  out  1  high while the CPU must stay in reset
- done  out  1  image loaded successfully (sticky)
- error  out  1  frame rejected (sticky)
- words_loaded  out  16  count of words written in the current frame

Behaviour:
- Clock and reset: single clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, ram_we=0, ram_waddr=BASE_ADDR, ram_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0, length=0.
- Reset mid-frame aborts the frame. RAM contents already written are left as they are.
- States and transitions (each on an accepted byte unless noted):
  - IDLE: SYNC_BYTE -> LEN_HI. Any other byte is accepted and discarded.
  - LEN_HI: length[15:8]=byte -> LEN_LO.
  - LEN_LO: length[7:0]=byte.
    - length==0 -> DONE (or CSUM if the feature is enabled).
    - length>MAX_WORDS -> ERROR.
    - otherwise -> DATA_HI.
  - DATA_HI: hold byte as the high byte -> DATA_LO.
  - DATA_LO: form word {hi, byte}.
    - On the next cycle: ram_we=1 for exactly one cycle, ram_wdata=word, ram_waddr=BASE_ADDR+words_loaded (modulo 2^ADDR_W); words_loaded increments in that same cycle.
    - After the last word -> DONE (or CSUM); otherwise -> DATA_HI.
  - DONE: done=1, cpu_hold=0, in_ready=0.
  - ERROR: error=1, cpu_hold=1, in_ready=0.
- Byte order: big-endian, high byte first.
- in_ready: 1 in IDLE, LEN_*, DATA_* and CSUM; 0 in DONE and ERROR. No other back-pressure. A write cycle may overlap acceptance of the next byte.
- restart:
  - In DONE or ERROR: go to IDLE on the next edge and clear done, error and words_loaded; cpu_hold=1.
  - In any other state: ignored.
- in_valid low: the state holds indefinitely. There is no timeout.
- Latency: last byte accepted -> ram_we on the next cycle. DONE and cpu_hold=0 take effect on the same edge as that final write strobe.

Optional Feature:
- Macro: LOADER_CSUM_EN.
- Defined:
  - After the last data byte (or after LEN_LO when length==0), the loader enters CSUM and expects one byte equal to the 8-bit modulo-256 sum of all data bytes (not sync, not length).
  - Match -> DONE. Mismatch -> ERROR.
  - Words are still written as they arrive; error keeps cpu_hold=1.
- Undefined: the CSUM state and running-sum register are absent, and the loader goes directly to DONE.

Decomposition:
- Shared package cpu_pkg holds:
  - the loader state enum (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERROR);
  - the SYNC_BYTE default;
  - the 16-bit word width constant, shared with the CPU and RAM.
- No sub-module. The design is a single FSM with a datapath (length, word count, sum registers).

Test Plan:
- Nominal load: bytes A5 00 02 10 00 40 00 -> writes 16'h1000@0 and 16'h4000@1, done=1, cpu_hold=0, words_loaded=2.
- Garbage before sync: 00 FF 3C then A5 00 01 F0 00 -> leading bytes discarded, single write 16'hF000@0, done=1.
- Oversize: A5 01 01 (length 257 > 256) -> error=1, ram_we never asserted, in_ready=0; restart -> IDLE, error=0.
- Reset mid-frame: assert reset after A5 00 03 12 -> all outputs at reset values, state IDLE. A following full frame loads correctly.
- Zero length and back-pressure: A5 00 00 -> done=1 with no writes. Frame with in_valid toggling 1/0 each cycle -> same writes as the nominal case.
- LOADER_CSUM_EN: A5 00 01 12 34 46 -> done=1. Last byte 47 -> error=1, cpu_hold=1, word 16'h1234 still written.
